// File: rtl/run_seq_pkg.sv
// Shared types and default widths for the run sequencer and its memory-port arbiter.
package run_seq_pkg;

   // Run controller states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      RUN    = 2'd2,
      FINISH = 2'd3
   } state_t;

   // Default data-memory address, data and cycle-counter widths.
   localparam int DEF_AW = 8;
   localparam int DEF_DW = 8;
   localparam int DEF_CW = 16;

   // The core owns the data-memory port while a run is being launched or executing.
   function automatic logic core_owns_port(input state_t s);
      return (s == START) || (s == RUN);
   endfunction

endpackage

// File: rtl/mem_port_arb.sv
// Data-memory port mux. The host owns the port while the core is idle or finished,
// and the core owns it during START and RUN. The host grant is purely combinational.
module mem_port_arb
   import run_seq_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
) (
   input  logic          core_owns,
   input  logic          host_mem_req,
   input  logic          host_mem_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_mem_ack,
   input  logic          core_mem_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata
);

   // Select the port owner. A core write can never reach memory while the host owns the port.
   always_comb begin
      host_mem_ack = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = host_addr;
      mem_wdata    = host_wdata;
      if (core_owns) begin
         mem_we    = core_mem_we;
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
      end else begin
         host_mem_ack = host_mem_req;
         mem_we       = host_mem_req & host_mem_we;
      end
   end

endmodule

// File: rtl/run_sequencer.sv
// Owns one program run on the single-cycle core: launches it with a one-cycle
// core_start, counts RUN cycles until core_done or timeout, and hands the data-memory
// port to the host whenever the core is not running.
module run_sequencer
   import run_seq_pkg::*;
#(
   parameter int          AW      = DEF_AW,
   parameter int          DW      = DEF_DW,
   parameter int          CW      = DEF_CW,
   parameter int unsigned TIMEOUT = 32'h0000_FFFF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          go,
   output logic          busy,
   output logic          finished,
   output logic          timed_out,
   output logic [CW-1:0] cyc_count,
   output logic          core_start,
   input  logic          core_done,
   input  logic          host_mem_req,
   input  logic          host_mem_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_mem_ack,
   input  logic          core_mem_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata
);

   // Count value in the last RUN cycle before the timeout forces FINISH.
   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cyc_count_nxt;
   logic            timed_out_nxt;
   logic            core_owns;

   // State, cycle counter and timeout flag registers, synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register updated from pre-edge values.
      if (reset) begin
         state     <= IDLE;
         cyc_count <= '0;
         timed_out <= 1'b0;
      end else begin
         state     <= state_nxt;
         cyc_count <= cyc_count_nxt;
         timed_out <= timed_out_nxt;
      end
   end

   // Next state, counter and timeout flag; core_done takes priority over the timeout.
   always_comb begin
      // NOTE: every output gets a hold default first, so no path can infer a latch.
      state_nxt     = state;
      cyc_count_nxt = cyc_count;
      timed_out_nxt = timed_out;
      case (state)
         IDLE, FINISH: begin
            if (go) begin
               state_nxt     = START;
               cyc_count_nxt = '0;
               timed_out_nxt = 1'b0;
            end
         end
         START: begin
            state_nxt = RUN;
         end
         RUN: begin
            if (core_done) begin
               state_nxt     = FINISH;
               timed_out_nxt = 1'b0;
            end else if (cyc_count == LAST_CNT) begin
               state_nxt     = FINISH;
               cyc_count_nxt = cyc_count + 1'b1;
               timed_out_nxt = 1'b1;
            end else begin
               cyc_count_nxt = cyc_count + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Moore status outputs decoded from the state alone.
   assign busy       = (state == START) || (state == RUN);
   assign finished   = (state == FINISH);
   assign core_start = (state == START);
   assign core_owns  = core_owns_port(state);

   mem_port_arb #(
      .AW (AW),
      .DW (DW)
   ) u_mem_port_arb (
      .core_owns    (core_owns),
      .host_mem_req (host_mem_req),
      .host_mem_we  (host_mem_we),
      .host_addr    (host_addr),
      .host_wdata   (host_wdata),
      .host_mem_ack (host_mem_ack),
      .core_mem_we  (core_mem_we),
      .core_addr    (core_addr),
      .core_wdata   (core_wdata),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata)
   );

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer with TIMEOUT=10: directed scenarios followed by randomized runs,
// each checked against a run-level model (expected count = min(done index, TIMEOUT)).
module tb_run_sequencer;

   localparam int AW      = 8;
   localparam int DW      = 8;
   localparam int CW      = 16;
   localparam int TIMEOUT = 10;

   logic          clk;
   logic          reset;
   logic          go;
   logic          busy;
   logic          finished;
   logic          timed_out;
   logic [CW-1:0] cyc_count;
   logic          core_start;
   logic          core_done;
   logic          host_mem_req;
   logic          host_mem_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_mem_ack;
   logic          core_mem_we;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;

   int vectors     = 0;
   int miscompares = 0;

   run_sequencer #(
      .AW      (AW),
      .DW      (DW),
      .CW      (CW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .go           (go),
      .busy         (busy),
      .finished     (finished),
      .timed_out    (timed_out),
      .cyc_count    (cyc_count),
      .core_start   (core_start),
      .core_done    (core_done),
      .host_mem_req (host_mem_req),
      .host_mem_we  (host_mem_we),
      .host_addr    (host_addr),
      .host_wdata   (host_wdata),
      .host_mem_ack (host_mem_ack),
      .core_mem_we  (core_mem_we),
      .core_addr    (core_addr),
      .core_wdata   (core_wdata),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete run: go pulse, START, RUN until core_done at RUN index done_at
   // (or timeout), then FINISH. Host holds a request throughout the run.
   task automatic do_run(input int done_at, input bit noisy_go);
      int end_k;
      int exp_cnt;
      bit exp_to;
      exp_to  = (done_at >= TIMEOUT);
      end_k   = exp_to ? TIMEOUT - 1 : done_at;
      exp_cnt = exp_to ? TIMEOUT : done_at;

      go = 1'b1;
      tick();
      go           = noisy_go ? 1'($urandom_range(0, 1)) : 1'b0;
      host_mem_req = 1'b1;
      host_mem_we  = 1'b1;
      host_addr    = 8'h33;
      host_wdata   = 8'h5A;
      core_mem_we  = 1'b0;
      #1;
      check("start_core_start", 32'(core_start), 32'd1);
      check("start_busy", 32'(busy), 32'd1);
      check("start_ack", 32'(host_mem_ack), 32'd0);
      tick();

      for (int k = 0; k <= end_k; k++) begin
         core_addr   = 8'($urandom);
         core_wdata  = 8'($urandom);
         core_mem_we = 1'($urandom_range(0, 1));
         core_done   = (k == done_at);
         go          = noisy_go ? 1'($urandom_range(0, 1)) : 1'b0;
         #1;
         check("run_cyc_count", 32'(cyc_count), 32'(k));
         check("run_core_start", 32'(core_start), 32'd0);
         check("run_busy", 32'(busy), 32'd1);
         check("run_finished", 32'(finished), 32'd0);
         check("run_ack", 32'(host_mem_ack), 32'd0);
         check("run_mem_addr", 32'(mem_addr), 32'(core_addr));
         check("run_mem_wdata", 32'(mem_wdata), 32'(core_wdata));
         check("run_mem_we", 32'(mem_we), 32'(core_mem_we));
         tick();
      end

      core_done   = 1'b0;
      go          = 1'b0;
      core_mem_we = 1'b1;
      host_mem_we = 1'b0;
      #1;
      check("fin_finished", 32'(finished), 32'd1);
      check("fin_busy", 32'(busy), 32'd0);
      check("fin_timed_out", 32'(timed_out), 32'(exp_to));
      check("fin_cyc_count", 32'(cyc_count), 32'(exp_cnt));
      check("fin_ack", 32'(host_mem_ack), 32'd1);
      check("fin_mem_addr", 32'(mem_addr), 32'h33);
      check("fin_core_we_blocked", 32'(mem_we), 32'd0);

      tick();
      check("hold_finished", 32'(finished), 32'd1);
      check("hold_cyc_count", 32'(cyc_count), 32'(exp_cnt));
      check("hold_timed_out", 32'(timed_out), 32'(exp_to));
      host_mem_req = 1'b0;
      core_mem_we  = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      go           = 1'b0;
      core_done    = 1'b0;
      host_mem_req = 1'b0;
      host_mem_we  = 1'b0;
      host_addr    = '0;
      host_wdata   = '0;
      core_mem_we  = 1'b0;
      core_addr    = '0;
      core_wdata   = '0;

      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_finished", 32'(finished), 32'd0);
      check("rst_timed_out", 32'(timed_out), 32'd0);
      check("rst_cyc_count", 32'(cyc_count), 32'd0);
      check("rst_core_start", 32'(core_start), 32'd0);
      check("rst_ack", 32'(host_mem_ack), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      reset = 1'b0;

      // Idle host write, granted in the same cycle; a core write is not passed through.
      tick();
      host_mem_req = 1'b1;
      host_mem_we  = 1'b1;
      host_addr    = 8'h08;
      host_wdata   = 8'hA5;
      core_mem_we  = 1'b1;
      core_addr    = 8'hF0;
      #1;
      check("idle_ack", 32'(host_mem_ack), 32'd1);
      check("idle_mem_we", 32'(mem_we), 32'd1);
      check("idle_mem_addr", 32'(mem_addr), 32'h08);
      check("idle_mem_wdata", 32'(mem_wdata), 32'hA5);
      host_mem_req = 1'b0;
      #1;
      check("idle_core_we_blocked", 32'(mem_we), 32'd0);
      check("idle_no_ack", 32'(host_mem_ack), 32'd0);
      core_mem_we = 1'b0;

      do_run(5, 1'b0);
      do_run(30, 1'b0);
      do_run(9, 1'b0);
      do_run(4, 1'b1);
      do_run(3, 1'b0);
      do_run(0, 1'b0);

      // Reset in the middle of a run.
      go = 1'b1;
      tick();
      go = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) tick();
      check("pre_reset_cyc_count", 32'(cyc_count), 32'd3);
      reset       = 1'b1;
      core_mem_we = 1'b1;
      tick();
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_finished", 32'(finished), 32'd0);
      check("mid_rst_timed_out", 32'(timed_out), 32'd0);
      check("mid_rst_cyc_count", 32'(cyc_count), 32'd0);
      check("mid_rst_core_start", 32'(core_start), 32'd0);
      check("mid_rst_ack", 32'(host_mem_ack), 32'd0);
      check("mid_rst_mem_we", 32'(mem_we), 32'd0);
      reset       = 1'b0;
      core_mem_we = 1'b0;
      tick();
      check("post_rst_core_start", 32'(core_start), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      do_run(2, 1'b0);

      for (int r = 0; r < 12; r++) begin
         do_run(int'($urandom_range(0, 14)), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Hard bound on simulation time so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion, required completion within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Controller that owns one program run on the single-cycle core. It accepts a `go` request from the host and issues the core's `start`. It then counts execution cycles until the core raises `done` or a timeout expires. It also arbitrates the shared data-memory port, so the host can preload operands and read back results only while the core is idle or finished. It sits between the testbench/host side and the core's `start`/`done` pins and data-memory port.

## Interface
Parameters:
- `AW`, 8, data-memory address width
- `DW`, 8, data-memory data width
- `CW`, 16, cycle-counter width
- `TIMEOUT`, 16'hFFFF, maximum RUN cycles before forced finish; must be ≥1 and < 2^CW

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `go`  in  1  host request to start a run
- `busy`  out  1  high in START and RUN
- `finished`  out  1  high in FINISH
- `timed_out`  out  1  last run ended by timeout; valid in FINISH
- `cyc_count`  out  CW  RUN-cycle count of current/last run
- `core_start`  out  1  drives core `start`
- `core_done`  in  1  core `done` (combinational from halt)
- `host_mem_req`  in  1  host memory access request
- `host_mem_we`  in  1  host write enable
- `host_addr`  in  AW  host address
- `host_wdata`  in  DW  host write data
- `host_mem_ack`  out  1  host access granted this cycle
- `core_mem_we`  in  1  core write enable
- `core_addr`  in  AW  core address
- `core_wdata`  in  DW  core write data
- `mem_we`  out  1  to data memory
- `mem_addr`  out  AW  to data memory
- `mem_wdata`  out  DW  to data memory

## Operation
- States: IDLE, START, RUN, FINISH. Moore outputs only.
- IDLE: `go` moves the block to START. Otherwise it stays in IDLE.
- START: lasts exactly one cycle, with `core_start`=1. `cyc_count` and `timed_out` clear. Next state is RUN.
- RUN: when `core_done`=1, go to FINISH with `timed_out`=0. Else, when `cyc_count`==TIMEOUT−1, increment and go to FINISH with `timed_out`=1. Otherwise increment `cyc_count`.
- When `core_done` and the timeout condition occur in the same cycle, done wins: `timed_out`=0 and `cyc_count` is not incremented.
- FINISH: outputs hold. `go` moves the block to START, which begins a new run.
- `go` is ignored in START and RUN. There is no queuing.
- Memory arbitration:
  - In IDLE/FINISH: `host_mem_ack`=`host_mem_req`, and the mem outputs are muxed from the host (`mem_we`=`host_mem_req & host_mem_we`).
  - In START/RUN: `host_mem_ack`=0 and the mem outputs come from the core. The host must hold its request until acked.
  - In IDLE/FINISH, core writes are blocked (`mem_we` never follows `core_mem_we`).
- `cyc_count` never wraps, because TIMEOUT < 2^CW.

## Timing
- Reset values:
  - state IDLE
  - `busy`=0, `finished`=0, `timed_out`=0
  - `cyc_count`=0, `core_start`=0, `host_mem_ack`=0
  - `mem_we`=0
- `go` high at edge N: START occupies cycle N+1 (`core_start`=1). The core's PC resets at edge N+1, and RUN begins at cycle N+2.
- `cyc_count` equals the number of RUN cycles before the cycle in which `core_done` was sampled high. If `done` is high in the first RUN cycle, the count is 0.
- FINISH is entered one edge after the terminating RUN cycle. `finished` and `timed_out` are visible from that cycle.
- Host memory grant is combinational, with zero-cycle latency, in IDLE/FINISH.
- Reset asserted mid-run returns to IDLE at the next edge and clears all outputs. `core_start` is not pulsed.

## Structure
- Shared package `run_seq_pkg`:
  - `state_t` enum {IDLE, START, RUN, FINISH}
  - default widths `AW`/`DW`/`CW`
- One sub-module, `mem_port_arb`: a combinational host/core mux with grant logic, selected by a `core_owns` signal from the FSM.
- The FSM and counter live in the top module.

## Test plan
- Reset, then `go` at cycle 3, with `core_done` rising after 5 RUN cycles → `core_start` high only in cycle 4; FINISH reached with `cyc_count`=5 and `timed_out`=0.
- TIMEOUT=10, `core_done` never rises → FINISH after 10 RUN cycles with `cyc_count`=10 and `timed_out`=1.
- TIMEOUT=10, `core_done` rises on the 10th RUN cycle → `timed_out`=0 and `cyc_count`=9.
- Host writes 0xA5 to address 0x08 in IDLE → acked the same cycle. A host request held during RUN gets `host_mem_ack`=0, and `mem_addr` follows `core_addr`. The held request acks in the first FINISH cycle.
- `go` pulsed during RUN → ignored, with a single run only. `go` in FINISH → a new START, and `cyc_count` cleared to 0.
- `reset` asserted in RUN at `cyc_count`=3 → next cycle all outputs are at their reset values, and `go` afterwards starts a clean run.
